// File: rtl/adder_if.sv
// adder_if: operand/result bundle for the adder.
//   master : drives A, B; observes out, co, sum_q, zero_q, ovf_q
//   slave  : the adder side
interface adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] out;
  logic             co;
  logic [WIDTH:0]   sum_q;
  logic             zero_q;
  logic             ovf_q;

  modport master (output A, B, input out, co, sum_q, zero_q, ovf_q);
  modport slave  (input A, B, output out, co, sum_q, zero_q, ovf_q);
endinterface

// File: rtl/adder.sv
// adder: gate-level ripple-carry adder with a one-cycle registered status copy.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (registers only)
//   bus.A/B    WIDTH-bit unsigned operands
//   bus.out    combinational (A+B) mod 2^WIDTH
//   bus.co     combinational carry-out
//   bus.sum_q  registered {co, out}
//   bus.zero_q registered out == 0 (ignores co)
//   bus.ovf_q  registered two's-complement overflow

// One full-adder cell, kept as explicit XOR/AND/OR to match the gate netlist.
module adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module adder #(
  parameter int WIDTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  adder_if.slave  bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   sum_d, sum_q;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    adder_fa u_fa (
      .a  (bus.A[i]),
      .b  (bus.B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign bus.out = s;
  assign bus.co  = c[WIDTH];

  // Overflow from the carries into and out of the sign cell; for WIDTH=1
  // c[0] is 0, so this collapses to co.
  always_comb begin
    sum_d  = {c[WIDTH], s};
    zero_d = (s == '0);
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.sum_q  = sum_q;
  assign bus.zero_q = zero_q;
  assign bus.ovf_q  = ovf_q;
endmodule

// File: tb/tb_adder.sv
module tb_adder;
  logic clk;
  logic rst_n;

  adder_if #(.WIDTH(4)) if4 ();
  adder_if #(.WIDTH(8)) if8 ();

  adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] sum;
    logic       zero;
    logic       ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, check the combinational result, then check
  // the registered copy after the following rising edge via the queue.
  task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic rst);
    logic [4:0] full;
    exp_t e;
    @(negedge clk);
    rst_n = ~rst;
    if4.A = a;
    if4.B = b;
    full = {1'b0, a} + {1'b0, b};
    e.sum  = rst ? 9'd0 : {4'd0, full};
    e.zero = rst ? 1'b1 : (full[3:0] == 4'd0);
    e.ovf  = rst ? 1'b0 : ((a[3] == b[3]) && (full[3] != a[3]));
    q4.push_back(e);
    #1;
    chk("out4", {60'd0, if4.out}, {60'd0, full[3:0]});
    chk("co4", {63'd0, if4.co}, {63'd0, full[4]});
    @(posedge clk);
    #1;
    e = q4.pop_front();
    chk("sum_q4", {59'd0, if4.sum_q}, {55'd0, e.sum});
    chk("zero_q4", {63'd0, if4.zero_q}, {63'd0, e.zero});
    chk("ovf_q4", {63'd0, if4.ovf_q}, {63'd0, e.ovf});
  endtask

  task automatic step8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    if8.A = a;
    if8.B = b;
    full = {1'b0, a} + {1'b0, b};
    e.sum  = full;
    e.zero = (full[7:0] == 8'd0);
    e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
    q8.push_back(e);
    #1;
    chk("sum8", {55'd0, if8.co, if8.out}, {55'd0, full});
    @(posedge clk);
    #1;
    e = q8.pop_front();
    chk("sum_q8", {55'd0, if8.sum_q}, {55'd0, e.sum});
    chk("zero_q8", {63'd0, if8.zero_q}, {63'd0, e.zero});
    chk("ovf_q8", {63'd0, if8.ovf_q}, {63'd0, e.ovf});
  endtask

  initial begin
    rst_n = 1'b0;
    if4.A = '0;
    if4.B = '0;
    if8.A = '0;
    if8.B = '0;

    // Reset state, then directed cases
    step4(4'd0, 4'd0, 1'b1);
    step4(4'd3, 4'd4, 1'b0);
    step4(4'd7, 4'd9, 1'b0);
    step4(4'd15, 4'd15, 1'b0);
    step4(4'd7, 4'd1, 1'b0);
    step4(4'd8, 4'd8, 1'b0);

    // Reset held two edges mid-operation, then release
    step4(4'd5, 4'd6, 1'b1);
    step4(4'd5, 4'd6, 1'b1);
    step4(4'd5, 4'd6, 1'b0);

    // Exhaustive WIDTH=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step4(4'(a), 4'(b), 1'b0);

    // Random WIDTH=8, plus corners
    step8(8'hFF, 8'hFF);
    step8(8'h7F, 8'h01);
    step8(8'h80, 8'h80);
    step8(8'h00, 8'h00);
    for (int i = 0; i < 1000; i++)
      step8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
